delay_line_fil: RTL and testbench
=================================

# delay_line_fil

Parametrised tapped delay line for the filter datapath: an enable-gated chain of `PROF` registers, each `LARGO` bits wide. Every stage is exposed so the downstream multiply-accumulate can read all taps in parallel. It is the multi-stage successor of the single enabled filter register. It adds a synchronous flush, a fill counter, a `lleno` flag and a one-cycle `dato_listo` strobe, so the MAC knows when the tap window is valid.

## Interface
- `LARGO`, 24, sample width in bits (≥1)
- `PROF`, 8, number of stages/taps (≥2)
- `CW`, $clog2(PROF+1), fill-counter width (derived, not overridden)

- `clk` input 1: single clock, rising edge
- `reset` input 1: synchronous, active-high; clears all stages, counter and flags
- `en` input 1: shift enable, one new sample accepted per cycle while high
- `clr` input 1: synchronous flush, same effect as `reset` but driven by control logic
- `entrada` input `LARGO`: new sample
- `taps` output `LARGO*PROF`: all stages, flattened; tap k is at [k*LARGO +: LARGO]; tap 0 is the newest sample
- `salida` output `LARGO`: oldest stage (tap PROF-1)
- `cuenta` output `CW`: samples held, saturates at PROF
- `lleno` output 1: high when `cuenta == PROF`
- `dato_listo` output 1: one-cycle pulse, registered; see Timing

## Operation
- **Shift when `en=1`, `reset=0`, `clr=0`:**
  - tap0 ← `entrada`
  - tap k ← tap k-1 for k = 1..PROF-1
  - oldest value is discarded
- **Hold when `en=0`:** all taps, `cuenta` and `lleno` keep their values.
- **Fill counter:**
  - increments by 1 on each shift while `cuenta < PROF`
  - holds at PROF once reached, with no wrap
- **`lleno`:** combinational compare of the registered `cuenta`, so it adds no extra latency.
- **`dato_listo`:** registered; set to 1 in the cycle after any shift that leaves the line full, 0 otherwise.
  - The shift that takes `cuenta` from PROF-1 to PROF produces the first pulse.
  - Every later shift while full produces a pulse.
- **Priority:** `reset` > `clr` > `en`.
  - `clr` with `en` in the same cycle flushes and discards `entrada`.
  - `clr` and `reset` assert `dato_listo` = 0 in the following cycle.
- **Reset values:** all taps 0, `salida` 0, `cuenta` 0, `lleno` 0, `dato_listo` 0.
- **Arithmetic:** none on data; samples are moved bit-exact with no sign extension.

## Timing
- Sample on `entrada` with `en=1` at edge N:
  - appears on tap0 after edge N
  - appears on `salida` after edge N+PROF-1, counting only enabled edges
- `cuenta`, `lleno`, `taps`, `salida` all update on the same edge as the shift.
- `dato_listo` is valid in the cycle after the shift edge, i.e. aligned with the taps that edge produced.
- `reset` or `clr` mid-fill (e.g. `cuenta=3`): the next edge gives all zeros and `cuenta=0`. Refill then needs PROF further enabled cycles before `lleno`.
- Back-to-back `en` gives one shift per cycle with no bubbles.
- Gaps in `en` only stretch latency in clock cycles.

## Structure
- **Shared package `fil_pkg`:**
  - default `LARGO` (24) and `PROF` (8)
  - tap-index helper function returning the bit offset k*LARGO
- **Sub-module `reg_en_cell`:**
  - one `LARGO`-bit register with synchronous reset/clear and enable
  - instantiated PROF times in a generate loop, chained tap k-1 → tap k
- **Top module:** owns the counter and the `lleno`/`dato_listo` logic only.

## Test plan
Bench parameters: `LARGO=8`, `PROF=4`.

1. **Reset:** assert `reset` with `en=1`, `entrada=0xFF` → `taps=0`, `cuenta=0`, `lleno=0`, `dato_listo=0` after the edge.
2. **Fill:** shift in 0x11, 0x22, 0x33, 0x44 on consecutive cycles →
   - `cuenta` steps 1,2,3,4
   - `lleno` goes high after the 4th edge
   - `taps` = {0x11,0x22,0x33,0x44} from tap3 down to tap0
   - `salida=0x11`
   - `dato_listo` pulses one cycle after the 4th edge
3. **Steady shift:** add 0x55 → `salida=0x22`, `cuenta` stays 4, `dato_listo` pulses again.
4. **Hold:** from the state after scenario 3, hold `en=0` for 5 cycles with `entrada` toggling → taps unchanged at {0x22,0x33,0x44,0x55}, `dato_listo=0`.
5. **Flush priority:** from the state after scenario 2, assert `clr=1` with `en=1`, `entrada=0x99` → all taps 0, `cuenta=0`, 0x99 absent.
6. **Gapped refill:** alternate `en` 1/0 while shifting 0xA1..0xA4 → `lleno` asserts only after the 4th enabled edge, and `salida=0xA1`.

Source files
------------

// File: rtl/fil_pkg.sv
// Shared definitions for the filter datapath: default widths and tap addressing.
package fil_pkg;

  localparam int unsigned LARGO_DEF = 24;
  localparam int unsigned PROF_DEF  = 8;

  // Bit offset of tap k inside the flattened tap vector.
  function automatic int unsigned tap_off(input int unsigned k, input int unsigned largo);
    return k * largo;
  endfunction

endpackage

// File: rtl/reg_en_cell.sv
// One delay-line stage: LARGO-bit register with synchronous reset, flush and enable.
module reg_en_cell
  import fil_pkg::*;
#(
  parameter int unsigned LARGO = LARGO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [LARGO-1:0] d,
  output logic [LARGO-1:0] q
);

  // Stage register; reset and clr both win over en.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/delay_line_fil.sv
// Tapped delay line with fill counter, full flag and a registered "window valid" strobe.
module delay_line_fil
  import fil_pkg::*;
#(
  parameter  int unsigned LARGO = LARGO_DEF,
  parameter  int unsigned PROF  = PROF_DEF,
  localparam int unsigned CW    = $clog2(PROF + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [LARGO-1:0]      entrada,
  output logic [LARGO*PROF-1:0] taps,
  output logic [LARGO-1:0]      salida,
  output logic [CW-1:0]         cuenta,
  output logic                  lleno,
  output logic                  dato_listo
);

  logic [LARGO-1:0] stage [PROF];
  logic [CW-1:0]    cuenta_q, cuenta_d;
  logic             listo_q, listo_d;

  for (genvar k = 0; k < PROF; k++) begin : g_stage
    logic [LARGO-1:0] d_in;
    if (k == 0) begin : g_head
      assign d_in = entrada;
    end else begin : g_chain
      assign d_in = stage[k-1];
    end

    reg_en_cell #(
      .LARGO(LARGO)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .clr  (clr),
      .en   (en),
      .d    (d_in),
      .q    (stage[k])
    );

    assign taps[tap_off(k, LARGO) +: LARGO] = stage[k];
  end

  assign salida     = stage[PROF-1];
  assign cuenta     = cuenta_q;
  assign lleno      = (cuenta_q == CW'(PROF));
  assign dato_listo = listo_q;

  // Next-state for the fill counter and strobe; reset is applied in the register.
  always_comb begin
    cuenta_d = cuenta_q;
    listo_d  = 1'b0;
    if (clr) begin
      cuenta_d = '0;
    end else if (en) begin
      if (cuenta_q != CW'(PROF)) begin
        cuenta_d = cuenta_q + CW'(1);
      end
      // Strobe follows every shift that leaves the line full.
      listo_d = (cuenta_d == CW'(PROF));
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta_q <= '0;
      listo_q  <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      listo_q  <= listo_d;
    end
  end

endmodule

// File: tb/tb_delay_line_fil.sv
// Directed bench for delay_line_fil with LARGO=8, PROF=4.
module tb_delay_line_fil;

  localparam int unsigned LARGO = 8;
  localparam int unsigned PROF  = 4;
  localparam int unsigned CW    = $clog2(PROF + 1);

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  en = 1'b0;
  logic                  clr = 1'b0;
  logic [LARGO-1:0]      entrada = '0;
  logic [LARGO*PROF-1:0] taps;
  logic [LARGO-1:0]      salida;
  logic [CW-1:0]         cuenta;
  logic                  lleno;
  logic                  dato_listo;

  int total = 0;
  int bad   = 0;

  delay_line_fil #(
    .LARGO(LARGO),
    .PROF (PROF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .entrada   (entrada),
    .taps      (taps),
    .salida    (salida),
    .cuenta    (cuenta),
    .lleno     (lleno),
    .dato_listo(dato_listo)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; clr = 1'b0; entrada = 8'hFF;
    tick();
    total++;
    if (taps !== 32'h0 || salida !== 8'h00 || cuenta !== 3'd0 || lleno !== 1'b0
        || dato_listo !== 1'b0) begin
      bad++;
      $display("FAIL reset: taps=%h salida=%h cuenta=%0d lleno=%b listo=%b want all zero",
               taps, salida, cuenta, lleno, dato_listo);
    end
    reset = 1'b0; en = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; entrada = vals[i];
      tick();
      total++;
      if (cuenta !== 3'(i + 1) || lleno !== (i == 3) || dato_listo !== (i == 3)
          || taps[7:0] !== vals[i]) begin
        bad++;
        $display("FAIL fill[%0d]: cuenta=%0d lleno=%b listo=%b tap0=%h want %0d %b %b %h",
                 i, cuenta, lleno, dato_listo, taps[7:0], i + 1, i == 3, i == 3, vals[i]);
      end
    end
    en = 1'b0;
    total++;
    if (taps !== 32'h11223344 || salida !== 8'h11) begin
      bad++;
      $display("FAIL fill_taps: taps=%h salida=%h want 11223344 11", taps, salida);
    end
  endtask

  task automatic test_steady();
    en = 1'b1; entrada = 8'h55;
    tick();
    en = 1'b0;
    total++;
    if (salida !== 8'h22 || cuenta !== 3'd4 || dato_listo !== 1'b1 || lleno !== 1'b1
        || taps !== 32'h22334455) begin
      bad++;
      $display("FAIL steady: salida=%h cuenta=%0d listo=%b lleno=%b taps=%h want 22 4 1 1 22334455",
               salida, cuenta, dato_listo, lleno, taps);
    end
  endtask

  task automatic test_hold();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      entrada = (i % 2 == 0) ? 8'hAA : 8'h5A;
      tick();
      total++;
      if (taps !== 32'h22334455 || dato_listo !== 1'b0 || cuenta !== 3'd4 || lleno !== 1'b1) begin
        bad++;
        $display("FAIL hold[%0d]: taps=%h listo=%b cuenta=%0d lleno=%b want 22334455 0 4 1",
                 i, taps, dato_listo, cuenta, lleno);
      end
    end
  endtask

  task automatic test_flush();
    clr = 1'b1; en = 1'b1; entrada = 8'h99;
    tick();
    total++;
    if (taps !== 32'h0 || cuenta !== 3'd0 || lleno !== 1'b0 || dato_listo !== 1'b0) begin
      bad++;
      $display("FAIL flush: taps=%h cuenta=%0d lleno=%b listo=%b want 0 0 0 0",
               taps, cuenta, lleno, dato_listo);
    end
    clr = 1'b0; en = 1'b0; entrada = 8'h00;
    tick();
    total++;
    if (taps !== 32'h0 || cuenta !== 3'd0) begin
      bad++;
      $display("FAIL flush_after: taps=%h cuenta=%0d want 0 0", taps, cuenta);
    end
  endtask

  task automatic test_gapped_refill();
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; entrada = 8'hA1 + 8'(i);
      tick();
      total++;
      if (cuenta !== 3'(i + 1) || lleno !== (i == 3) || dato_listo !== (i == 3)) begin
        bad++;
        $display("FAIL gap_on[%0d]: cuenta=%0d lleno=%b listo=%b want %0d %b %b",
                 i, cuenta, lleno, dato_listo, i + 1, i == 3, i == 3);
      end
      en = 1'b0; entrada = 8'hEE;
      tick();
      total++;
      if (cuenta !== 3'(i + 1) || dato_listo !== 1'b0) begin
        bad++;
        $display("FAIL gap_off[%0d]: cuenta=%0d listo=%b want %0d 0", i, cuenta, dato_listo, i + 1);
      end
    end
    total++;
    if (salida !== 8'hA1 || taps !== 32'hA1A2A3A4) begin
      bad++;
      $display("FAIL gap_taps: salida=%h taps=%h want A1 A1A2A3A4", salida, taps);
    end
  endtask

  task automatic test_mid_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      entrada = 8'hC0 + 8'(i);
      tick();
    end
    reset = 1'b1; entrada = 8'hFF;
    tick();
    reset = 1'b0;
    total++;
    if (taps !== 32'h0 || cuenta !== 3'd0 || dato_listo !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: taps=%h cuenta=%0d listo=%b want 0 0 0", taps, cuenta, dato_listo);
    end
    for (int i = 0; i < 4; i++) begin
      entrada = 8'h01 + 8'(i);
      tick();
      total++;
      if (lleno !== (i == 3) || cuenta !== 3'(i + 1)) begin
        bad++;
        $display("FAIL refill[%0d]: lleno=%b cuenta=%0d want %b %0d", i, lleno, cuenta, i == 3, i + 1);
      end
    end
    // Saturation: a further shift keeps the count at PROF.
    entrada = 8'h05;
    tick();
    en = 1'b0;
    total++;
    if (cuenta !== 3'd4 || salida !== 8'h02 || dato_listo !== 1'b1) begin
      bad++;
      $display("FAIL saturate: cuenta=%0d salida=%h listo=%b want 4 02 1", cuenta, salida, dato_listo);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_steady();
    test_hold();
    test_reset();
    test_fill();
    test_flush();
    test_gapped_refill();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
